// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block: state encoding and
// default timing constants for a 50 MHz board clock.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int DEF_TICK_DIV   = 50000000;
    localparam int DEF_DIV_W      = 26;
    localparam int DEF_DEB_CYCLES = 500000;
    localparam int DEF_DEB_W      = 19;

    function automatic logic is_counting(input state_t s);
        return (s == ST_RUN) || (s == ST_LAP);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle event on each accepted rising level.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int DEB_W      = DEF_DEB_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic evt
);

    localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             acc;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            acc   <= 1'b0;
            cnt   <= '0;
            evt   <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            evt   <= 1'b0;
            if (sync2 != acc) begin
                // The level must have differed for DEB_CYCLES consecutive cycles.
                if (cnt == LAST) begin
                    acc <= sync2;
                    cnt <= '0;
                    evt <= sync2;
                end else begin
                    cnt <= cnt + DEB_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: run/pause/lap FSM, one-second tick prescaler,
// counter clear pulse and the lap display latch.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int DEB_W      = DEF_DEB_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] ls_in,
    input  logic [3:0] hs_in,
    output logic       tick,
    output logic       cnt_clr,
    output logic [3:0] disp_ls,
    output logic [3:0] disp_hs,
    output logic       running,
    output logic       lap_frozen
);

    localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_DIV - 1);

    state_t           st;
    state_t           st_nx;
    logic [DIV_W-1:0] pre;
    logic [DIV_W-1:0] pre_nx;
    logic             tick_nx;
    logic             clr_nx;
    logic             ev_ss;
    logic             ev_lr;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_ss (
        .clk(clk), .rst(rst), .btn_raw(btn_ss), .evt(ev_ss)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_lr (
        .clk(clk), .rst(rst), .btn_raw(btn_lr), .evt(ev_lr)
    );

    // ev_ss is tested first everywhere, so a coincident ev_lr is dropped.
    always_comb begin
        st_nx  = st;
        clr_nx = 1'b0;
        case (st)
            ST_IDLE: begin
                if (ev_ss)      st_nx = ST_RUN;
                else if (ev_lr) clr_nx = 1'b1;
            end
            ST_RUN: begin
                if (ev_ss)      st_nx = ST_PAUSE;
                else if (ev_lr) st_nx = ST_LAP;
            end
            ST_LAP: begin
                if (ev_ss)      st_nx = ST_PAUSE;
                else if (ev_lr) st_nx = ST_RUN;
            end
            ST_PAUSE: begin
                if (ev_ss) begin
                    st_nx = ST_RUN;
                end else if (ev_lr) begin
                    st_nx  = ST_IDLE;
                    clr_nx = 1'b1;
                end
            end
            default: st_nx = ST_IDLE;
        endcase
    end

    // The tick depends only on the current state, so it survives a state exit.
    always_comb begin
        tick_nx = is_counting(st) && (pre == TERM);
        pre_nx  = pre;
        case (st)
            ST_RUN, ST_LAP: pre_nx = (pre == TERM) ? '0 : pre + DIV_W'(1);
            ST_PAUSE:       pre_nx = clr_nx ? '0 : pre;
            default:        pre_nx = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= ST_IDLE;
            pre        <= '0;
            tick       <= 1'b0;
            cnt_clr    <= 1'b0;
            running    <= 1'b0;
            lap_frozen <= 1'b0;
            disp_ls    <= 4'd0;
            disp_hs    <= 4'd0;
        end else begin
            st         <= st_nx;
            pre        <= pre_nx;
            tick       <= tick_nx;
            cnt_clr    <= clr_nx;
            running    <= is_counting(st_nx);
            lap_frozen <= (st_nx == ST_LAP);
            // Entering LAP captures on this edge; only a held LAP freezes.
            if (st != ST_LAP) begin
                disp_ls <= ls_in;
                disp_hs <= hs_in;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=3: directed scenarios
// and random button traffic checked every cycle against a behavioural model.
module tb_stopwatch_ctrl;

    localparam int TD  = 4;
    localparam int DEB = 3;

    // Model modes, named in the stopwatch user's terms.
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;
    localparam int M_LAP    = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_lr;
    logic [3:0] ls_in;
    logic [3:0] hs_in;
    logic       tick;
    logic       cnt_clr;
    logic [3:0] disp_ls;
    logic [3:0] disp_hs;
    logic       running;
    logic       lap_frozen;

    int checks = 0;
    int errors = 0;
    bit rand_digits = 1'b0;

    // Reference model state
    int         m_mode;
    int         m_phase;
    logic       m_tick;
    logic       m_clr;
    logic [3:0] m_dls;
    logic [3:0] m_dhs;
    logic       m_acc [2];
    logic       m_ev  [2];
    logic       m_h   [2][2];
    int         m_run [2];

    stopwatch_ctrl #(.TICK_DIV(TD), .DIV_W(3), .DEB_CYCLES(DEB), .DEB_W(2)) dut (
        .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lr(btn_lr),
        .ls_in(ls_in), .hs_in(hs_in), .tick(tick), .cnt_clr(cnt_clr),
        .disp_ls(disp_ls), .disp_hs(disp_hs), .running(running),
        .lap_frozen(lap_frozen)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_phase = 0;
        m_tick  = 1'b0;
        m_clr   = 1'b0;
        m_dls   = 4'd0;
        m_dhs   = 4'd0;
        for (int b = 0; b < 2; b++) begin
            m_acc[b]  = 1'b0;
            m_ev[b]   = 1'b0;
            m_h[b][0] = 1'b0;
            m_h[b][1] = 1'b0;
            m_run[b]  = 0;
        end
    endtask

    task automatic model_edge();
        int   nmode;
        logic counting;
        logic raw [2];
        logic syn;
        if (!rst) begin
            model_reset();
        end else begin
            counting = (m_mode == M_RUN) || (m_mode == M_LAP);
            nmode    = m_mode;
            m_clr    = 1'b0;
            if (m_ev[0]) begin
                nmode = counting ? M_PAUSE : M_RUN;
            end else if (m_ev[1]) begin
                if (m_mode == M_IDLE)       m_clr = 1'b1;
                else if (m_mode == M_RUN)   nmode = M_LAP;
                else if (m_mode == M_LAP)   nmode = M_RUN;
                else begin nmode = M_IDLE;  m_clr = 1'b1; end
            end
            m_tick = counting && (m_phase == TD - 1);
            if (counting)                m_phase = (m_phase + 1) % TD;
            else if (m_mode == M_IDLE)   m_phase = 0;
            else if (m_clr)              m_phase = 0;
            if (m_mode != M_LAP) begin
                m_dls = ls_in;
                m_dhs = hs_in;
            end
            m_mode = nmode;
            // Button path: synchronised level is the raw sample from two edges ago.
            raw[0] = btn_ss;
            raw[1] = btn_lr;
            for (int b = 0; b < 2; b++) begin
                syn       = m_h[b][1];
                m_h[b][1] = m_h[b][0];
                m_h[b][0] = raw[b];
                m_ev[b]   = 1'b0;
                if (syn != m_acc[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DEB) begin
                        m_acc[b] = syn;
                        m_run[b] = 0;
                        m_ev[b]  = syn;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic exp_run;
        logic exp_lap;
        exp_run = (m_mode == M_RUN) || (m_mode == M_LAP);
        exp_lap = (m_mode == M_LAP);
        chk("tick",       {3'b0, tick},       {3'b0, m_tick});
        chk("cnt_clr",    {3'b0, cnt_clr},    {3'b0, m_clr});
        chk("running",    {3'b0, running},    {3'b0, exp_run});
        chk("lap_frozen", {3'b0, lap_frozen}, {3'b0, exp_lap});
        chk("disp_ls",    disp_ls,            m_dls);
        chk("disp_hs",    disp_hs,            m_dhs);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_digits) begin
                ls_in = 4'($urandom_range(9, 0));
                hs_in = 4'($urandom_range(5, 0));
            end
            @(posedge clk);
            model_edge();
            #1;
            compare_all();
        end
    endtask

    task automatic press(input logic ss, input logic lr, input int hold, input int gap);
        btn_ss = ss;
        btn_lr = lr;
        cycles(hold);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        cycles(gap);
    endtask

    // Drops rst between clock edges and checks the outputs before the next edge.
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_running", {3'b0, running}, 4'd0);
        cycles(2);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        ls_in  = 4'd0;
        hs_in  = 4'd0;
        model_reset();
        #1;
        compare_all();
        cycles(2);
        @(negedge clk);
        rst = 1'b1;

        // 1: idle after reset, display follows live digits
        rand_digits = 1'b1;
        cycles(20);

        // 2: clean start press, ticks every 4 cycles, then a short glitch
        press(1'b1, 1'b0, 10, 12);
        chk("run_after_ss", {3'b0, running}, 4'd1);
        press(1'b1, 1'b0, 2, 8);
        chk("glitch_ignored", {3'b0, running}, 4'd1);

        // 3: pause holds partial second, resume continues it
        press(1'b1, 1'b0, 5, 11);
        chk("paused", {3'b0, running}, 4'd0);
        press(1'b1, 1'b0, 5, 9);

        // 4: lap freezes 7/3 while live digits advance
        rand_digits = 1'b0;
        ls_in = 4'd7;
        hs_in = 4'd3;
        press(1'b0, 1'b1, 6, 2);
        ls_in = 4'd8;
        cycles(2);
        ls_in = 4'd9;
        cycles(5);
        chk("lap_hold_ls", disp_ls, 4'd7);
        chk("lap_hold_hs", disp_hs, 4'd3);
        press(1'b0, 1'b1, 6, 4);
        chk("lap_release_ls", disp_ls, 4'd9);
        rand_digits = 1'b1;

        // 5: pause, clear back to idle, restart from zero prescaler
        press(1'b1, 1'b0, 5, 6);
        press(1'b0, 1'b1, 5, 6);
        chk("cleared_idle", {3'b0, running}, 4'd0);
        press(1'b1, 1'b0, 5, 12);

        // 6: simultaneous buttons from RUN, then async reset mid-RUN
        press(1'b1, 1'b1, 6, 6);
        chk("simul_pause", {3'b0, lap_frozen}, 4'd0);
        press(1'b1, 1'b0, 5, 7);
        async_reset();
        cycles(4);

        // Random button traffic with occasional asynchronous resets
        for (int it = 0; it < 60; it++) begin
            press(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  $urandom_range(8, 1), $urandom_range(8, 1));
            if ($urandom_range(14, 0) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
